// File: rtl/apb_reg_bank_pkg.sv
// Shared types and helpers for the APB register bank: FSM states, LOCK index, byte merge.
package apb_reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LOCK_IDX   = 0;
  localparam int WAIT_CNT_W = 3;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: 'start' flags an access that must pass through WAIT,
// 'done' marks the last WAIT cycle.
module apb_wait_ctr
  import apb_reg_bank_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic active,
  output logic start,
  output logic done
);

  logic [WAIT_CNT_W-1:0] cnt_reg;
  logic [WAIT_CNT_W-1:0] cnt_next;

  assign start = launch && (WAIT_CYCLES != 0);
  assign done  = active && (cnt_reg == WAIT_CNT_W'(WAIT_CYCLES - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (launch) begin
      cnt_next = '0;
    end else if (active && !done) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/apb_reg_bank.sv
// APB register bank with LOCK register, byte strobes and optional wait states.
// Optional feature: define APB_REG_BANK_PSLVERR_EN to flag out-of-range and locked writes.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 64,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                    pclk_i,
  input  logic                    prst_n_i,
  input  logic                    pmodsel_i,
  input  logic                    penable_i,
  input  logic [ADDR_W-1:0]       paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_W-1:0]       pwdata_i,
  input  logic [DATA_W/8-1:0]     pstrb_i,
  output logic [DATA_W-1:0]       prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [DEPTH*DATA_W-1:0] regs_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;

  state_t                   state_reg;
  logic [IDX_W-1:0]         idx_hold_reg;
  logic                     wr_hold_reg;
  logic [DATA_W-1:0]        wdata_hold_reg;
  logic [STRB_W-1:0]        strb_hold_reg;
  logic                     pready_reg;
  logic                     pslverr_reg;
  logic [DATA_W-1:0]        prdata_reg;
  logic                     lock_reg;
  logic [DEPTH-1:0][DATA_W-1:0] reg_view;

  logic             access;
  logic             ctr_start;
  logic             ctr_done;
  logic             enter_resp;
  logic [IDX_W-1:0] idx_cur;
  logic             wr_cur;
  logic             in_range_cur;
  logic             locked_cur;
  logic             err_cur;
  logic             wr_fire;
  logic [DATA_W-1:0] rd_cur;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^paddr_i[1:0];

  assign access     = (state_reg == IDLE) && pmodsel_i && penable_i;
  assign enter_resp = (access && !ctr_start) || ((state_reg == WAIT) && ctr_done);

  // With no wait states RESP is entered from IDLE before the holding registers load,
  // so decode straight from the bus in IDLE and from the holding registers otherwise.
  assign idx_cur      = (state_reg == IDLE) ? paddr_i[ADDR_W-1:2] : idx_hold_reg;
  assign wr_cur       = (state_reg == IDLE) ? pwrite_i : wr_hold_reg;
  assign in_range_cur = {1'b0, idx_cur} < (IDX_W + 1)'(DEPTH);
  assign locked_cur   = lock_reg && wr_cur && (idx_cur != IDX_W'(LOCK_IDX));
  assign wr_fire      = (state_reg == RESP) && wr_cur && in_range_cur && !locked_cur;

`ifdef APB_REG_BANK_PSLVERR_EN
  assign err_cur = !in_range_cur || locked_cur;
`else
  assign err_cur = 1'b0;
`endif

  always_comb begin
    rd_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_cur == IDX_W'(i)) begin
        rd_cur = reg_view[i];
      end
    end
  end

  apb_wait_ctr #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_ctr (
    .clk   (pclk_i),
    .rst_n (prst_n_i),
    .launch(access),
    .active(state_reg == WAIT),
    .start (ctr_start),
    .done  (ctr_done)
  );

  always_ff @(posedge pclk_i) begin
    if (!prst_n_i) begin
      state_reg      <= IDLE;
      idx_hold_reg   <= '0;
      wr_hold_reg    <= 1'b0;
      wdata_hold_reg <= '0;
      strb_hold_reg  <= '0;
      pready_reg     <= 1'b0;
      pslverr_reg    <= 1'b0;
      prdata_reg     <= '0;
    end else begin
      pready_reg  <= enter_resp;
      pslverr_reg <= enter_resp && err_cur;
      prdata_reg  <= enter_resp ? rd_cur : '0;
      case (state_reg)
        IDLE: begin
          if (access) begin
            idx_hold_reg   <= paddr_i[ADDR_W-1:2];
            wr_hold_reg    <= pwrite_i;
            wdata_hold_reg <= pwdata_i;
            strb_hold_reg  <= pstrb_i;
            state_reg      <= ctr_start ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (ctr_done) begin
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!prst_n_i) begin
      lock_reg <= 1'b0;
    end else if (wr_fire && (idx_cur == IDX_W'(LOCK_IDX)) && strb_hold_reg[0]) begin
      lock_reg <= wdata_hold_reg[0];
    end
  end

  assign reg_view[0] = {{(DATA_W-1){1'b0}}, lock_reg};

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] q_next;

    for (genvar gb = 0; gb < STRB_W; gb++) begin : g_byte
      assign q_next[gb*8 +: 8] = merge_byte(q_reg[gb*8 +: 8], wdata_hold_reg[gb*8 +: 8],
                                            strb_hold_reg[gb]);
    end

    always_ff @(posedge pclk_i) begin
      if (!prst_n_i) begin
        q_reg <= RST_VAL;
      end else if (wr_fire && (idx_cur == IDX_W'(gi))) begin
        q_reg <= q_next;
      end
    end

    assign reg_view[gi] = q_reg;
  end

  assign regs_o    = reg_view;
  assign prdata_o  = prdata_reg;
  assign pready_o  = pready_reg;
  assign pslverr_o = pslverr_reg;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: dut0 has no wait states, dut3 has three.
`timescale 1ns/1ps
module tb_apb_reg_bank;

  localparam int          DW  = 32;
  localparam int          AW  = 16;
  localparam int          DEP = 64;
  localparam logic [31:0] RV  = 32'h1122_3344;
`ifdef APB_REG_BANK_PSLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              psel   [2];
  logic              pen    [2];
  logic              pwr    [2];
  logic [AW-1:0]     paddr  [2];
  logic [DW-1:0]     pwdata [2];
  logic [3:0]        pstrb  [2];
  logic [DW-1:0]     prdata [2];
  logic              pready [2];
  logic              pslverr[2];
  logic [DEP*DW-1:0] regs   [2];

  int errors = 0;
  int checks = 0;

  apb_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(0), .RST_VAL(RV)) dut0 (
    .pclk_i(clk), .prst_n_i(rst_n), .pmodsel_i(psel[0]), .penable_i(pen[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwr[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]), .regs_o(regs[0])
  );

  apb_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(3), .RST_VAL(RV)) dut3 (
    .pclk_i(clk), .prst_n_i(rst_n), .pmodsel_i(psel[1]), .penable_i(pen[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwr[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]), .regs_o(regs[1])
  );

  function automatic logic [31:0] reg_of(input logic [DEP*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Setup phase, then access phase held until pready; lat counts access cycles (0 = timeout).
  task automatic xfer(input int d, input logic [15:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int lat);
    lat = 0;
    rd  = '0;
    err = 1'b0;
    @(posedge clk); #1;
    psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = a; pwr[d] = w; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    pen[d] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pready[d]) begin
        lat = n;
        rd  = prdata[d];
        err = pslverr[d];
        break;
      end
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; pen[d] = 1'b0;
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%b -> rdata=%h err=%0b lat=%0d",
             d, w ? "WR" : "RD", a, wd, st, rd, err, lat);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (reg_of(regs[d], 1) !== RV) begin
        errors++; $display("FAIL reset_reg1 dut%0d: got %h expected %h", d, reg_of(regs[d], 1), RV);
      end
      checks++;
      if (reg_of(regs[d], 0) !== 32'h0) begin
        errors++; $display("FAIL reset_lock dut%0d: got %h expected 0", d, reg_of(regs[d], 0));
      end
      checks++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got pready=%b pslverr=%b prdata=%h expected 0/0/0",
                 d, pready[d], pslverr[d], prdata[d]);
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 16'h0008, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, err, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL strobe_wr_lat: got %0d expected 2", lat); end
    checks++;
    if (rd !== RV) begin errors++; $display("FAIL strobe_wr_prev: got %h expected %h", rd, RV); end
    checks++;
    if (reg_of(regs[0], 2) !== 32'h11BB_33DD) begin
      errors++; $display("FAIL strobe_reg2: got %h expected 11bb33dd", reg_of(regs[0], 2));
    end
    xfer(0, 16'h000B, 1'b0, 32'h0, 4'b0000, rd, err, lat);
    checks++;
    if (rd !== 32'h11BB_33DD || lat !== 2 || err !== 1'b0) begin
      errors++; $display("FAIL strobe_rd: got %h lat=%0d err=%b expected 11bb33dd lat=2 err=0", rd, lat, err);
    end
    @(negedge clk);
    checks++;
    if (prdata[0] !== 32'h0) begin errors++; $display("FAIL idle_prdata: got %h expected 0", prdata[0]); end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic err; int lat; int seen;
    xfer(1, 16'h0004, 1'b0, 32'h0, 4'b0000, rd, err, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wait_rd_lat: got %0d expected 5", lat); end
    checks++;
    if (rd !== RV) begin errors++; $display("FAIL wait_rd_data: got %h expected %h", rd, RV); end
    // Drop the select after the first access cycle: the captured write must still finish.
    @(posedge clk); #1;
    psel[1] = 1'b1; pen[1] = 1'b0; paddr[1] = 16'h0014; pwr[1] = 1'b1;
    pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    lat = 0; seen = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 2) begin psel[1] = 1'b0; pen[1] = 1'b0; end
      if (pready[1]) begin
        seen++;
        if (lat == 0) lat = n;
      end
    end
    $display("xfer dut1 WR addr=0014 wdata=cafef00d (select dropped early) lat=%0d pulses=%0d", lat, seen);
    checks++;
    if (lat !== 5 || seen !== 1) begin
      errors++; $display("FAIL wait_drop: got lat=%0d pulses=%0d expected lat=5 pulses=1", lat, seen);
    end
    checks++;
    if (reg_of(regs[1], 5) !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL wait_drop_reg5: got %h expected cafef00d", reg_of(regs[1], 5));
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 16'h0000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, lat);
    checks++;
    if (reg_of(regs[0], 0) !== 32'h1) begin
      errors++; $display("FAIL lock_set: got %h expected 1", reg_of(regs[0], 0));
    end
    xfer(0, 16'h0000, 1'b0, 32'h0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL lock_read: got %h expected 1", rd); end
    xfer(0, 16'h0004, 1'b1, 32'h5, 4'hF, rd, err, lat);
    checks++;
    if (err !== EXP_ERR) begin errors++; $display("FAIL lock_err: got %b expected %b", err, EXP_ERR); end
    checks++;
    if (reg_of(regs[0], 1) !== RV) begin
      errors++; $display("FAIL lock_discard: got %h expected %h", reg_of(regs[0], 1), RV);
    end
    xfer(0, 16'h0000, 1'b1, 32'h0, 4'h1, rd, err, lat);
    xfer(0, 16'h0004, 1'b1, 32'h5, 4'hF, rd, err, lat);
    checks++;
    if (reg_of(regs[0], 1) !== 32'h5 || err !== 1'b0) begin
      errors++; $display("FAIL unlock_write: got %h err=%b expected 00000005 err=0", reg_of(regs[0], 1), err);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 16'h0100, 1'b0, 32'h0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0 || err !== EXP_ERR) begin
      errors++; $display("FAIL oor_read: got %h err=%b expected 0 err=%b", rd, err, EXP_ERR);
    end
    xfer(0, 16'h0100, 1'b1, 32'h1, 4'hF, rd, err, lat);
    checks++;
    if (err !== EXP_ERR || reg_of(regs[0], 0) !== 32'h0) begin
      errors++; $display("FAIL oor_write: got err=%b reg0=%h expected err=%b reg0=0", err, reg_of(regs[0], 0), EXP_ERR);
    end
    xfer(0, 16'h00FC, 1'b0, 32'h0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== RV || err !== 1'b0) begin
      errors++; $display("FAIL last_reg_read: got %h err=%b expected %h err=0", rd, err, RV);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int pulse_at [3];
    int k;
    vals[0] = 32'h0000_0A0A; vals[1] = 32'h0000_0B0B; vals[2] = 32'h0000_0C0C;
    k = 0;
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1; pstrb[0] = 4'hF;
    paddr[0] = 16'h0010; pwdata[0] = vals[0];
    for (int c = 1; c <= 20 && k < 3; c++) begin
      @(negedge clk);
      if (pready[0]) begin
        pulse_at[k] = c;
        k++;
        if (k < 3) begin
          paddr[0] = 16'(16'h0010 + 16'(4 * k)); pwdata[0] = vals[k];
        end else begin
          psel[0] = 1'b0; pen[0] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    $display("xfer dut0 back-to-back x3 pulses=%0d at cycles %0d %0d %0d", k, pulse_at[0], pulse_at[1], pulse_at[2]);
    checks++;
    if (k !== 3 || pulse_at[0] !== 2 || pulse_at[1] !== 4 || pulse_at[2] !== 6) begin
      errors++; $display("FAIL b2b_timing: got %0d pulses at %0d/%0d/%0d expected 3 at 2/4/6",
                         k, pulse_at[0], pulse_at[1], pulse_at[2]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (reg_of(regs[0], 4 + i) !== vals[i]) begin
        errors++; $display("FAIL b2b_reg%0d: got %h expected %h", 4 + i, reg_of(regs[0], 4 + i), vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat; int seen;
    @(posedge clk); #1;
    psel[1] = 1'b1; pen[1] = 1'b0; paddr[1] = 16'h000C; pwr[1] = 1'b1;
    pwdata[1] = 32'hDEAD_BEEF; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; pen[1] = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (pready[1]) seen++;
    end
    $display("xfer dut1 WR addr=000c wdata=deadbeef aborted by reset, pready pulses after=%0d", seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_pready: got %0d pulses expected 0", seen); end
    checks++;
    if (reg_of(regs[1], 3) !== RV) begin
      errors++; $display("FAIL abort_reg3: got %h expected %h", reg_of(regs[1], 3), RV);
    end
    xfer(1, 16'h000C, 1'b0, 32'h0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== RV || lat !== 5) begin
      errors++; $display("FAIL abort_recover: got %h lat=%0d expected %h lat=5", rd, lat, RV);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_strobe();
    test_wait();
    test_lock();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register and APB data width, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 16, APB address width.
REQ-003 The block SHALL have parameter DEPTH, default 64, number of registers, 2..2^(ADDR_W-2).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, extra wait states per access, range 0..7.
REQ-005 The block SHALL have parameter RST_VAL, default 0, DATA_W-bit reset value of registers 1..DEPTH-1.
REQ-006 The block SHALL have port pclk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port prst_n_i, input, 1 bit, reset; synchronous and active-low.
REQ-008 The block SHALL have port pmodsel_i, input, 1 bit, APB slave select.
REQ-009 The block SHALL have port penable_i, input, 1 bit, APB access phase.
REQ-010 The block SHALL have port paddr_i, input, ADDR_W bits, byte address; register index = paddr_i[ADDR_W-1:2]; bits [1:0] are ignored.
REQ-011 The block SHALL have port pwrite_i, input, 1 bit, 1 = write and 0 = read.
REQ-012 The block SHALL have port pwdata_i, input, DATA_W bits, write data.
REQ-013 The block SHALL have port pstrb_i, input, DATA_W/8 bits, byte write strobes.
REQ-014 The block SHALL have port prdata_o, output, DATA_W bits, read data, valid only while pready_o=1.
REQ-015 The block SHALL have port pready_o, output, 1 bit, transfer complete.
REQ-016 The block SHALL have port pslverr_o, output, 1 bit, transfer error, valid only while pready_o=1.
REQ-017 The block SHALL have port regs_o, output, DEPTH*DATA_W bits, flat copy of all registers; register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-018 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-019 In IDLE, pmodsel_i=1 and penable_i=1 SHALL capture paddr_i, pwrite_i, pwdata_i and pstrb_i into holding registers; the FSM goes to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-020 WAIT SHALL count exactly WAIT_CYCLES cycles and then go to RESP.
REQ-021 RESP SHALL assert pready_o for exactly one cycle and return to IDLE; pready_o first rises WAIT_CYCLES+1 cycles after the first access-phase cycle.
REQ-022 A write SHALL update only the bytes whose pstrb_i bit is 1, at the clock edge that ends RESP.
REQ-023 prdata_o SHALL carry the register value as it stood before any same-transfer update, and SHALL be 0 outside RESP.
REQ-024 Register 0 SHALL be the LOCK register: only bit 0 is implemented and the other bits read 0.
REQ-025 While LOCK[0]=1, writes to registers 1..DEPTH-1 SHALL be discarded; register 0 always remains writable.
REQ-026 An index >= DEPTH SHALL read 0 and a write to it SHALL be discarded.
REQ-027 If pmodsel_i or penable_i drops before RESP, the captured transfer SHALL still complete; the request is not re-sampled until IDLE.
REQ-028 Back-to-back transfers SHALL cost WAIT_CYCLES+2 cycles each, including one IDLE cycle between them.

Reset
REQ-029 With prst_n_i=0 at a clock edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, pready_o, pslverr_o and prdata_o SHALL be 0, LOCK SHALL be 0 and registers 1..DEPTH-1 SHALL be RST_VAL.
REQ-030 A reset during WAIT or RESP SHALL abort the transfer with no register update.

Configuration
REQ-031 With macro APB_REG_BANK_PSLVERR_EN defined, pslverr_o SHALL be 1 in RESP for an out-of-range index or a locked write, with data still discarded.
REQ-032 Without APB_REG_BANK_PSLVERR_EN, pslverr_o SHALL be tied to 0 and all other behaviour SHALL be unchanged.

Structure
REQ-033 The package apb_reg_bank_pkg SHALL hold the FSM state enum, LOCK_IDX=0 and the byte-merge function.
REQ-034 A sub-module apb_wait_ctr SHALL hold the wait-state counter, with parameter WAIT_CYCLES and outputs start and done.

Verification
REQ-035 The bench SHALL check reset values: after reset, regs_o[1] = RST_VAL, LOCK = 0 and pready_o = 0.
REQ-036 The bench SHALL check a strobed write with WAIT_CYCLES=0: write 0xAABBCCDD to 0x0008 with pstrb_i=4'b0101 over 0x11223344, then read back 0x11BB33DD; pready_o is high in the 2nd access cycle.
REQ-037 The bench SHALL check wait states with WAIT_CYCLES=3: a read of 0x0004 asserts pready_o exactly 4 cycles after the first access cycle.
REQ-038 The bench SHALL check lock: write 1 to 0x0000, then write 0x5 to 0x0004; register 1 is unchanged and pslverr_o=1 only with APB_REG_BANK_PSLVERR_EN defined.
REQ-039 The bench SHALL check out-of-range access with DEPTH=64: a read of 0x0100 returns 0, and pslverr_o follows the macro.
REQ-040 The bench SHALL check reset mid-transfer: assert prst_n_i in WAIT during a write; no update occurs and the FSM is in IDLE on the next cycle.
